// File: rtl/seg_scan_display_if.sv
// Load port for seg_scan_display: a digit set offered with valid/ready.
// Optional SEG_SCAN_BLINK_EN adds a per-digit blink mask carried with the codes.
interface seg_scan_display_if #(
  parameter int NUM_DIGITS = 6
);
  // Transfer happens on a rising clk edge where load_valid && load_ready are both 1;
  // the source holds codes_in/dp_in (and blink_mask) stable while load_valid is high.
  logic                    load_valid;
  logic                    load_ready;
  logic [5*NUM_DIGITS-1:0] codes_in;
  logic [NUM_DIGITS-1:0]   dp_in;
`ifdef SEG_SCAN_BLINK_EN
  logic [NUM_DIGITS-1:0]   blink_mask;

  modport master (output load_valid, codes_in, dp_in, blink_mask, input load_ready);
  modport slave  (input load_valid, codes_in, dp_in, blink_mask, output load_ready);
`else
  modport master (output load_valid, codes_in, dp_in, input load_ready);
  modport slave  (input load_valid, codes_in, dp_in, output load_ready);
`endif
endinterface

// File: rtl/seg_scan_display.sv
// Multiplexed common-anode seven-segment driver with frame-boundary data apply.
// Optional blinking of masked digits when SEG_SCAN_BLINK_EN is defined.
module seg_scan_display #(
  parameter int NUM_DIGITS  = 6,
  parameter int SCAN_DIV    = 50000,
  parameter int DEAD_CYCLES = 4,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg_scan_display_if.slave     load_if,
  input  logic                  lz_en,
  output logic [6:0]            seg_data,
  output logic                  seg_dp,
  output logic [NUM_DIGITS-1:0] seg_sel,
  output logic                  frame_tick
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  if (SCAN_DIV <= DEAD_CYCLES + 1 || BLINK_DIV < 1) begin : g_bad_params
    $error("seg_scan_display: SCAN_DIV must exceed DEAD_CYCLES+1 and BLINK_DIV must be positive");
  end

  function automatic logic [6:0] seg_decode(input logic [4:0] code);
    case (code)
      5'd0:  seg_decode = 7'h40;  5'd1:  seg_decode = 7'h79;
      5'd2:  seg_decode = 7'h24;  5'd3:  seg_decode = 7'h30;
      5'd4:  seg_decode = 7'h19;  5'd5:  seg_decode = 7'h12;
      5'd6:  seg_decode = 7'h02;  5'd7:  seg_decode = 7'h78;
      5'd8:  seg_decode = 7'h00;  5'd9:  seg_decode = 7'h10;
      5'd10: seg_decode = 7'h08;  5'd11: seg_decode = 7'h03;
      5'd12: seg_decode = 7'h46;  5'd13: seg_decode = 7'h21;
      5'd14: seg_decode = 7'h06;  5'd15: seg_decode = 7'h0E;
      5'd17: seg_decode = 7'h3F;
      default: seg_decode = 7'h7F;
    endcase
  endfunction

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic                  wrap_q;
  logic [6:0]            seg_data_q, seg_data_d;
  logic                  seg_dp_q, seg_dp_d;
  logic [NUM_DIGITS-1:0] seg_sel_q, seg_sel_d;
  logic                  frame_tick_q;
  logic                  pend_full_q, pend_full_d;
  logic [4:0]            pend_code_q [NUM_DIGITS];
  logic [4:0]            pend_code_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
  logic [4:0]            disp_code_q [NUM_DIGITS];
  logic [4:0]            disp_code_d [NUM_DIGITS];
  logic [NUM_DIGITS-1:0] disp_dp_q, disp_dp_d;
  logic [NUM_DIGITS-1:0] lz_supp;
  logic                  lz_run;
  logic                  frame_end, capture, apply, digit_blank;

  assign frame_end = (cnt_q == CW'(SCAN_DIV - 1)) && (idx_q == IW'(NUM_DIGITS - 1));
  assign capture   = load_if.load_valid && !pend_full_q;
  assign apply     = frame_end && pend_full_q;

  // A digit is suppressed while every digit from the top down to it is a plain zero.
  always_comb begin
    lz_supp = '0;
    lz_run  = lz_en;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      lz_run     = lz_run && (disp_code_q[i] == 5'd0) && !disp_dp_q[i];
      lz_supp[i] = lz_run;
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0]         blink_cnt_q;
  logic                  blink_off_q;
  logic [NUM_DIGITS-1:0] pend_blink_q, disp_blink_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_q  <= '0;
      blink_off_q  <= 1'b0;
      pend_blink_q <= '0;
      disp_blink_q <= '0;
    end else begin
      if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
        blink_cnt_q <= '0;
        blink_off_q <= ~blink_off_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + BW'(1);
      end
      if (apply)   disp_blink_q <= pend_blink_q;
      if (capture) pend_blink_q <= load_if.blink_mask;
    end
  end

  assign digit_blank = lz_supp[idx_q] || (blink_off_q && disp_blink_q[idx_q]);
`else
  assign digit_blank = lz_supp[idx_q];
`endif

  always_comb begin
    cnt_d       = cnt_q + CW'(1);
    idx_d       = idx_q;
    pend_full_d = pend_full_q;
    pend_code_d = pend_code_q;
    pend_dp_d   = pend_dp_q;
    disp_code_d = disp_code_q;
    disp_dp_d   = disp_dp_q;
    if (cnt_q == CW'(SCAN_DIV - 1)) begin
      cnt_d = '0;
      idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + IW'(1);
    end
    // Capture needs an empty pending register and apply needs a full one, so they never collide.
    if (apply) begin
      disp_code_d = pend_code_q;
      disp_dp_d   = pend_dp_q;
      pend_full_d = 1'b0;
    end
    if (capture) begin
      for (int i = 0; i < NUM_DIGITS; i++) pend_code_d[i] = load_if.codes_in[5*i +: 5];
      pend_dp_d   = load_if.dp_in;
      pend_full_d = 1'b1;
    end
    seg_sel_d  = (cnt_q < CW'(DEAD_CYCLES)) ? '1 : ~(NUM_DIGITS'(1) << idx_q);
    seg_data_d = digit_blank ? 7'h7F : seg_decode(disp_code_q[idx_q]);
    seg_dp_d   = digit_blank ? 1'b1 : ~disp_dp_q[idx_q];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      wrap_q       <= 1'b0;
      frame_tick_q <= 1'b0;
      seg_data_q   <= 7'h7F;
      seg_dp_q     <= 1'b1;
      seg_sel_q    <= '1;
      pend_full_q  <= 1'b0;
      pend_dp_q    <= '0;
      disp_dp_q    <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        pend_code_q[i] <= 5'd0;
        disp_code_q[i] <= 5'd16;
      end
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      wrap_q       <= frame_end;
      frame_tick_q <= wrap_q;
      seg_data_q   <= seg_data_d;
      seg_dp_q     <= seg_dp_d;
      seg_sel_q    <= seg_sel_d;
      pend_full_q  <= pend_full_d;
      pend_code_q  <= pend_code_d;
      pend_dp_q    <= pend_dp_d;
      disp_code_q  <= disp_code_d;
      disp_dp_q    <= disp_dp_d;
    end
  end

  assign load_if.load_ready = ~pend_full_q;
  assign seg_data           = seg_data_q;
  assign seg_dp             = seg_dp_q;
  assign seg_sel            = seg_sel_q;
  assign frame_tick         = frame_tick_q;
endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display with 4 digits, 8-clock slots and 2 dead clocks.
module tb_seg_scan_display;
  localparam int ND = 4;
  localparam int SD = 8;
  localparam int DC = 2;
  localparam int FRAME = ND * SD;

  logic       clk;
  logic       rst_n = 1'b1;
  logic       lz_en;
  logic [6:0] seg_data;
  logic       seg_dp;
  logic [3:0] seg_sel;
  logic       frame_tick;

  seg_scan_display_if #(.NUM_DIGITS(ND)) lif ();

  seg_scan_display #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYCLES(DC), .BLINK_DIV(64)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load_if(lif), .lz_en(lz_en),
    .seg_data(seg_data), .seg_dp(seg_dp), .seg_sel(seg_sel), .frame_tick(frame_tick)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: scan position counted from reset release, one frame = 32 clocks.
  logic [6:0] seg_tab [32];
  logic [4:0] m_disp [ND];
  logic [4:0] m_pend [ND];
  logic [3:0] m_disp_dp, m_pend_dp;
  bit         m_full, m_cap, m_app, m_blank;
  int         m_pos, m_slot_cnt, m_idx;
  logic [6:0] exp_data;
  logic       exp_dp, exp_tick, exp_ready;
  logic [3:0] exp_sel;

  initial begin
    for (int c = 0; c < 32; c++) seg_tab[c] = 7'h7F;
    seg_tab[0] = 7'h40;  seg_tab[1] = 7'h79;  seg_tab[2] = 7'h24;  seg_tab[3] = 7'h30;
    seg_tab[4] = 7'h19;  seg_tab[5] = 7'h12;  seg_tab[6] = 7'h02;  seg_tab[7] = 7'h78;
    seg_tab[8] = 7'h00;  seg_tab[9] = 7'h10;  seg_tab[10] = 7'h08; seg_tab[11] = 7'h03;
    seg_tab[12] = 7'h46; seg_tab[13] = 7'h21; seg_tab[14] = 7'h06; seg_tab[15] = 7'h0E;
    seg_tab[17] = 7'h3F;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < ND; j++) begin
        m_disp[j] = 5'd16;
        m_pend[j] = 5'd0;
      end
      m_disp_dp = '0; m_pend_dp = '0; m_full = 1'b0; m_pos = 0;
      exp_data = 7'h7F; exp_dp = 1'b1; exp_sel = 4'hF; exp_tick = 1'b0; exp_ready = 1'b1;
    end else begin
      m_slot_cnt = m_pos % SD;
      m_idx      = (m_pos / SD) % ND;
      exp_sel    = (m_slot_cnt < DC) ? 4'hF : ~(4'b0001 << m_idx);
      m_blank    = 1'b0;
      if (lz_en && m_idx > 0) begin
        m_blank = 1'b1;
        for (int j = m_idx; j < ND; j++)
          if (m_disp[j] != 5'd0 || m_disp_dp[j]) m_blank = 1'b0;
      end
      exp_data = m_blank ? 7'h7F : seg_tab[m_disp[m_idx]];
      exp_dp   = m_blank ? 1'b1 : ~m_disp_dp[m_idx];
      exp_tick = (m_pos % FRAME == 0) && (m_pos > 0);
      m_cap = lif.load_valid && !m_full;
      m_app = (m_pos % FRAME == FRAME - 1) && m_full;
      if (m_app) begin
        m_disp = m_pend; m_disp_dp = m_pend_dp; m_full = 1'b0;
      end
      if (m_cap) begin
        for (int j = 0; j < ND; j++) m_pend[j] = lif.codes_in[5*j +: 5];
        m_pend_dp = lif.dp_in; m_full = 1'b1;
      end
      exp_ready = !m_full;
      m_pos++;
    end
  end

  // Scoreboard compare on every falling edge
  always @(negedge clk) begin
    if (cmp_on) begin
      chk("cmp_seg_data", seg_data, exp_data);
      chk("cmp_seg_dp", seg_dp, exp_dp);
      chk("cmp_seg_sel", seg_sel, exp_sel);
      chk("cmp_frame_tick", frame_tick, exp_tick);
      chk("cmp_load_ready", lif.load_ready, exp_ready);
    end
  end

  // Driver tasks
  task automatic send(input logic [19:0] c, input logic [3:0] d);
    logic r;
    int   n;
    n = 0;
    lif.codes_in = c; lif.dp_in = d; lif.load_valid = 1'b1;
    do begin
      r = lif.load_ready;
      @(negedge clk);
      n++;
    end while (!r && n < 200);
    lif.load_valid = 1'b0;
    if (!r) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_tick && n < 100);
    if (!frame_tick) chk("tick_timeout", 32'd0, 32'd1);
  endtask

  // Starting at a frame_tick cycle, samples each digit mid-slot; returns at slot 3 + 4.
  logic [6:0] got_data [ND];
  logic       got_dp   [ND];
  logic [3:0] got_sel  [ND];
  task automatic read_frame();
    for (int i = 0; i < ND; i++) begin
      repeat ((i == 0) ? 4 : 8) @(negedge clk);
      got_data[i] = seg_data; got_dp[i] = seg_dp; got_sel[i] = seg_sel;
    end
  endtask

  int n_e, n_t, n_bad, tick_at;

  initial begin
    lif.load_valid = 1'b0; lif.codes_in = '0; lif.dp_in = '0; lz_en = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
    lif.blink_mask = '0;
`endif
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_seg_data", seg_data, 7'h7F);
    chk("rst_seg_dp", seg_dp, 1'b1);
    chk("rst_seg_sel", seg_sel, 4'hF);
    chk("rst_frame_tick", frame_tick, 1'b0);
    chk("rst_load_ready", lif.load_ready, 1'b1);
    rst_n = 1'b1;
    cmp_on = 1'b1;

    // Idle scan, nothing loaded
    n_e = 0; n_t = 0; n_bad = 0; tick_at = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (seg_sel == 4'hE) n_e++;
      if (frame_tick) begin n_t++; tick_at = k; end
      if (seg_data != 7'h7F) n_bad++;
    end
    chk("idle_sel_E_cycles", n_e, 12);
    chk("idle_tick_count", n_t, 1);
    chk("idle_tick_edge", tick_at, 33);
    chk("idle_blank_cycles", n_bad, 0);

    // Mid-frame load, then a refused second load while pending is full
    send({5'd3, 5'd2, 5'd1, 5'd0}, 4'b0010);
    chk("load_ready_low", lif.load_ready, 1'b0);
    lif.codes_in = {5'd9, 5'd9, 5'd9, 5'd9}; lif.dp_in = 4'b1111; lif.load_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("busy_ready_low", lif.load_ready, 1'b0);
    end
    lif.load_valid = 1'b0;
    chk("pre_apply_blank", seg_data, 7'h7F);
    wait_tick();
    chk("apply_d0_dead_data", seg_data, 7'h40);
    chk("apply_d0_dead_sel", seg_sel, 4'hF);
    @(negedge clk);
    chk("ready_after_tick", lif.load_ready, 1'b1);
    repeat (11) @(negedge clk);
    chk("d1_data", seg_data, 7'h79);
    chk("d1_dp", seg_dp, 1'b0);
    chk("d1_sel", seg_sel, 4'hD);
    repeat (8) @(negedge clk);
    chk("d2_data", seg_data, 7'h24);
    repeat (8) @(negedge clk);
    chk("d3_data", seg_data, 7'h30);
    chk("d3_sel", seg_sel, 4'h7);

    // Retry accepted, then leading-zero suppression on and off
    send({5'd0, 5'd0, 5'd5, 5'd0}, 4'b0000);
    chk("retry_ready_low", lif.load_ready, 1'b0);
    lz_en = 1'b1;
    wait_tick();
    read_frame();
    chk("lz_on_d0", got_data[0], 7'h40);
    chk("lz_on_d1", got_data[1], 7'h12);
    chk("lz_on_d2", got_data[2], 7'h7F);
    chk("lz_on_d3", got_data[3], 7'h7F);
    chk("lz_on_d2_sel", got_sel[2], 4'hB);
    lz_en = 1'b0;
    wait_tick();
    read_frame();
    chk("lz_off_d2", got_data[2], 7'h40);
    chk("lz_off_d3", got_data[3], 7'h40);
    chk("lz_off_d1", got_data[1], 7'h12);

    // Dash / blank / letters, then reset mid-digit with pending data outstanding
    send({5'd17, 5'd16, 5'd10, 5'd15}, 4'b0000);
    wait_tick();
    read_frame();
    chk("sym_d0", got_data[0], 7'h0E);
    chk("sym_d1", got_data[1], 7'h08);
    chk("sym_d2", got_data[2], 7'h7F);
    chk("sym_d3", got_data[3], 7'h3F);
    chk("sym_d3_dp", got_dp[3], 1'b1);
    wait_tick();
    send({5'd8, 5'd8, 5'd8, 5'd8}, 4'b1111);
    repeat (19) @(negedge clk);
    chk("pre_rst_sel", seg_sel, 4'hB);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_sel", seg_sel, 4'hF);
    chk("mid_rst_data", seg_data, 7'h7F);
    chk("mid_rst_dp", seg_dp, 1'b1);
    chk("mid_rst_ready", lif.load_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    wait_tick();
    read_frame();
    for (int i = 0; i < ND; i++) chk("post_rst_blank", got_data[i], 7'h7F);
    chk("post_rst_dp", got_dp[0], 1'b1);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
